// File: rtl/axil_read_config_bridge_if.sv
// Word-addressed configuration read channel: request (valid/ready/addr) followed by
// a response (valid/ready/data/error). The bridge drives it through the m modport.
interface read_config_i #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32
);
  logic                 read_valid;
  logic                 read_ready;
  logic [ADDR_BITS-1:0] read_addr;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DATA_BITS-1:0] resp_data;
  logic                 resp_error;

  modport m (
    output read_valid, read_addr, resp_ready,
    input  read_ready, resp_valid, resp_data, resp_error
  );

  modport s (
    input  read_valid, read_addr, resp_ready,
    output read_ready, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/axil_read_config_bridge.sv
// AXI4-Lite read slave that forwards one word-addressed read at a time onto a
// read_config_i master port, with a response timeout and late-response draining.
module axil_read_config_bridge #(
  parameter int AXIL_ADDR_BITS   = 32,
  parameter int AXIL_DATA_BITS   = 32,
  parameter int READ_ADDR_BITS   = 16,
  parameter int WORD_OFFSET_BITS = 2,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXIL_ADDR_BITS-1:0] araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [AXIL_DATA_BITS-1:0] rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  read_config_i.m                   out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    RESPOND
  } state_t;

  state_t                    state;
  logic                      stale;
  logic [CNT_W-1:0]          cnt;
  logic [READ_ADDR_BITS-1:0] addr_q;
  logic                      ar_hs;
  logic                      timeout_hit;

  assign ar_hs       = arvalid && arready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // Handshake outputs decode from state and stale only, so no input reaches an output.
  assign arready        = (state == IDLE) && !stale;
  assign rvalid         = (state == RESPOND);
  assign out.read_valid = (state == ISSUE);
  assign out.read_addr  = addr_q;
  assign out.resp_ready = (state == WAIT_RESP) || stale;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking writes would make ordering within the block matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      stale  <= 1'b0;
      cnt    <= '0;
      addr_q <= '0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else begin
      // A late response after a timeout is swallowed here; it never produces an R beat.
      if (stale && out.resp_valid) stale <= 1'b0;

      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            addr_q <= READ_ADDR_BITS'(araddr >> WORD_OFFSET_BITS);
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (out.read_ready) begin
            cnt   <= '0;
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A response on the timeout cycle takes priority over the timeout.
          if (out.resp_valid) begin
            rdata <= out.resp_data;
            rresp <= out.resp_error ? 2'b10 : 2'b00;
            state <= RESPOND;
          end else if (timeout_hit) begin
            rdata <= '0;
            rresp <= 2'b10;
            stale <= 1'b1;
            state <= RESPOND;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESPOND: begin
          if (rready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
